dendy_mem_arbiter: RTL and testbench
====================================

Name: dendy_mem_arbiter

Overview:
- Parametrised N-channel arbiter that time-multiplexes CPU, PPU fetch, OAM DMA and similar requesters onto one single-port synchronous RAM.
- The RAM has 1-cycle registered read latency, the same model as the PRG/CHR/OAM arrays in the system bench.
- It replaces per-client dedicated memory arrays with one shared array plus grant/read-valid handshakes.
- It supports round-robin or fixed-priority arbitration, plus a per-channel lock for back-to-back DMA bursts.

Parameters:
- CHANNELS, 4, number of requesters (2..8).
- AW, 16, address width.
- DW, 8, data width.
- MODE, 0, arbitration policy: 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  CHANNELS  per-channel request; held until the matching gnt is seen.
- we  in  CHANNELS  per-channel write enable, qualified by req.
- lock  in  CHANNELS  keep grant on this channel next cycle while its req stays high.
- addr  in  CHANNELS*AW  packed addresses; channel i is at [i*AW +: AW].
- wdata  in  CHANNELS*DW  packed write data; channel i is at [i*DW +: DW].
- gnt  out  CHANNELS  one-hot; access accepted this cycle.
- rvalid  out  CHANNELS  one-hot; read data for that channel is on rdata.
- rdata  out  DW  read data, broadcast to all channels; meaningful only with rvalid.
- mem_a  out  AW  RAM address.
- mem_d  out  DW  RAM write data.
- mem_w  out  1  RAM write strobe.
- mem_q  in  DW  RAM read data, valid one cycle after mem_a is presented.

Behaviour:
- Reset (synchronous, active-high):
  - While reset is high: gnt=0, mem_w=0, rvalid=0, rdata=0, mem_a=0, mem_d=0.
  - Round-robin pointer last = CHANNELS-1, so channel 0 wins first. Lock owner is cleared.
  - Any read that was in flight when reset asserted produces no rvalid.
- Arbitration (combinational in cycle t):
  - Candidates are channels with req=1.
  - MODE 0: the winner is the first candidate scanning last+1, last+2, ... (mod CHANNELS).
  - MODE 1: the winner is the lowest-index candidate.
  - Lock override: if the previous cycle's winner had lock=1 and its req is still 1, it wins regardless of policy.
  - gnt[winner]=1. mem_a, mem_d and mem_w (=we[winner]) are driven from the winner in the same cycle.
  - No candidate: gnt=0, mem_w=0, mem_a holds its last value.
- State update at the edge ending cycle t:
  - last <- winner, only in MODE 0 and only when a grant occurred.
  - Lock owner <- winner if lock[winner]=1, else cleared.
- Read return:
  - A read granted in cycle t gives rvalid[winner]=1 in cycle t+1, with rdata=mem_q registered through.
  - rvalid is a 1-cycle pulse. Reads are fully pipelined: one read per cycle, back-to-back across channels.
- Writes: produce no rvalid. A write then a read to the same address in consecutive cycles returns the new data; RAM ordering provides this.
- Requester rule: a requester may drop req or change addr only after seeing gnt. The arbiter does not latch addr.
- Fairness: in MODE 0 with no locks, a channel holding req waits at most CHANNELS-1 cycles. MODE 1 and lock give no starvation bound.
- Width rules:
  - The winner index is $clog2(CHANNELS) bits.
  - The pointer increment wraps from CHANNELS-1 to 0 for non-power-of-two CHANNELS; no out-of-range index is ever used.
- Simultaneous events:
  - req and we are ignored while reset is high.
  - A lock owner that drops req releases the lock that cycle; normal arbitration applies in the same cycle.

Test Plan:
- Reset behaviour: hold reset 3 cycles with all req=1 -> gnt=0 and mem_w=0 throughout; first grant after release is channel 0 (MODE 0).
- Round-robin rotation: MODE 0, CHANNELS=4, req=4'b1111 reads continuously -> gnt sequence 0,1,2,3,0; each rvalid one cycle after its gnt; rdata equals preloaded RAM[addr], e.g. addr 16'h2000 -> 8'h24.
- Write then read: ch1 writes 8'hA5 to 16'h0300, then ch2 reads 16'h0300 the next cycle -> rvalid[2] with rdata=8'hA5; no rvalid for ch1.
- Fixed priority: MODE 1, req=4'b1010 -> ch1 granted every cycle while held; ch3 is granted only after ch1 drops req.
- Lock burst: ch2 holds lock=1 with 256 consecutive reads while ch0 requests -> 256 consecutive gnt[2] pulses, then ch0 granted the cycle after ch2 drops req.
- Reset mid-read: grant a ch3 read, assert reset the next cycle -> rvalid stays 0; after release, arbitration restarts at ch0.

Source files
------------

// File: rtl/dendy_mem_arbiter.sv
// N-channel arbiter onto one single-port sync RAM: grant and RAM drive in the request cycle, rvalid one cycle later.
// Backpressure: a requester holds req/addr until it sees gnt; lock keeps the grant on a bursting channel.
module dendy_mem_arbiter #(
  parameter int CHANNELS = 4,
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MODE     = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    req,
  input  logic [CHANNELS-1:0]    we,
  input  logic [CHANNELS-1:0]    lock,
  input  logic [CHANNELS*AW-1:0] addr,
  input  logic [CHANNELS*DW-1:0] wdata,
  output logic [CHANNELS-1:0]    gnt,
  output logic [CHANNELS-1:0]    rvalid,
  output logic [DW-1:0]          rdata,
  output logic [AW-1:0]          mem_a,
  output logic [DW-1:0]          mem_d,
  output logic                   mem_w,
  input  logic [DW-1:0]          mem_q
);

  localparam int IW = $clog2(CHANNELS);

  logic [IW-1:0]       last;
  logic [IW-1:0]       lock_own;
  logic                lock_vld;
  logic [IW-1:0]       win;
  logic                any;
  logic [CHANNELS-1:0] req_g;
  logic [AW-1:0]       a_hold;
  logic [DW-1:0]       d_hold;
  logic [CHANNELS-1:0] rvalid_q;

  always_comb begin
    int c;
    c     = 0;
    req_g = reset ? '0 : req;
    win   = '0;
    any   = 1'b0;
    if (lock_vld && req_g[lock_own]) begin
      win = lock_own;
      any = 1'b1;
    end else if (MODE == 1) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (req_g[IW'(i)]) begin
          win = IW'(i);
          any = 1'b1;
        end
      end
    end else begin
      // Scan backwards so the nearest channel after last is assigned last and wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        c = int'(last) + k;
        if (c >= CHANNELS) c = c - CHANNELS;
        if (req_g[IW'(c)]) begin
          win = IW'(c);
          any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any) gnt[win] = 1'b1;
    mem_w = any & we[win];
    if (reset) begin
      mem_a = '0;
      mem_d = '0;
    end else if (any) begin
      mem_a = addr[int'(win)*AW +: AW];
      mem_d = wdata[int'(win)*DW +: DW];
    end else begin
      mem_a = a_hold;
      mem_d = d_hold;
    end
    // Gating with reset kills a read that was in flight when reset rose.
    rvalid = reset ? '0 : rvalid_q;
    rdata  = (|rvalid) ? mem_q : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last     <= IW'(CHANNELS - 1);
      lock_vld <= 1'b0;
      lock_own <= '0;
      a_hold   <= '0;
      d_hold   <= '0;
      rvalid_q <= '0;
    end else begin
      if (any) begin
        a_hold <= mem_a;
        d_hold <= mem_d;
        if (MODE == 0) last <= win;
      end
      lock_vld <= any & lock[win];
      lock_own <= win;
      rvalid_q <= '0;
      if (any && !we[win]) rvalid_q[win] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dendy_mem_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus, each with its own RAM model.
module tb_dendy_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req, we, lock;
  logic [63:0] addr;
  logic [31:0] wdata;

  logic [3:0]  g0, rv0, g1, rv1;
  logic [7:0]  rd0, md0, mq0, rd1, md1, mq1;
  logic [15:0] ma0, ma1;
  logic        mw0, mw1;

  logic [7:0]  ram0 [0:65535];
  logic [7:0]  ram1 [0:65535];

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  dendy_mem_arbiter #(.CHANNELS(4), .AW(16), .DW(8), .MODE(0)) u0 (
    .clock(clock), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(g0), .rvalid(rv0), .rdata(rd0),
    .mem_a(ma0), .mem_d(md0), .mem_w(mw0), .mem_q(mq0));

  dendy_mem_arbiter #(.CHANNELS(4), .AW(16), .DW(8), .MODE(1)) u1 (
    .clock(clock), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(g1), .rvalid(rv1), .rdata(rd1),
    .mem_a(ma1), .mem_d(md1), .mem_w(mw1), .mem_q(mq1));

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[15:8] + a[7:0] + 8'h04;
  endfunction

  // RAM models: 1-cycle registered read, contents reloaded with the pattern during reset.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 65536; i++) begin
        ram0[i] <= pat(16'(i));
        ram1[i] <= pat(16'(i));
      end
      mq0 <= '0;
      mq1 <= '0;
    end else begin
      if (mw0) ram0[ma0] <= md0;
      if (mw1) ram1[ma1] <= md1;
      mq0 <= ram0[ma0];
      mq1 <= ram1[ma1];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_addr(input int ch, input logic [15:0] a);
    addr[ch*16 +: 16] = a;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] g0;
    logic [3:0] g1;
    logic [3:0] rv0;
    logic [3:0] rv1;
    logic [7:0] rd0;
    logic [7:0] rd1;
  } vec_t;

  vec_t tab [12];

  initial begin
    int n0, n1, e0;
    tab[0]  = '{4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8'h00, 8'h00};
    tab[1]  = '{4'b1111, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 8'h24, 8'h24};
    tab[2]  = '{4'b1111, 4'b0100, 4'b0001, 4'b0010, 4'b0001, 8'h26, 8'h24};
    tab[3]  = '{4'b1111, 4'b1000, 4'b0001, 4'b0100, 4'b0001, 8'h28, 8'h24};
    tab[4]  = '{4'b1111, 4'b0001, 4'b0001, 4'b1000, 4'b0001, 8'h2A, 8'h24};
    tab[5]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 8'h24, 8'h24};
    tab[6]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 8'h00};
    tab[7]  = '{4'b1010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 8'h00, 8'h00};
    tab[8]  = '{4'b1010, 4'b1000, 4'b0010, 4'b0010, 4'b0010, 8'h26, 8'h26};
    tab[9]  = '{4'b1010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 8'h2A, 8'h26};
    tab[10] = '{4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 8'h26, 8'h26};
    tab[11] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 8'h2A, 8'h2A};

    reset = 1'b1;
    req   = 4'b1111;
    we    = 4'b1111;
    lock  = 4'b0000;
    wdata = 32'h5A5A5A5A;
    set_addr(0, 16'h2000);
    set_addr(1, 16'h2101);
    set_addr(2, 16'h2202);
    set_addr(3, 16'h2303);
    #1;

    // Reset held 3 cycles with every channel requesting a write.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("reset_gnt0", 32'(g0), 32'h0);
      chk("reset_gnt1", 32'(g1), 32'h0);
      chk("reset_mem_w", 32'(mw0 | mw1), 32'h0);
      chk("reset_rvalid", 32'(rv0), 32'h0);
      chk("reset_mem_a", 32'(ma0), 32'h0);
      nxt();
    end
    reset = 1'b0;
    we    = 4'b0000;

    for (int i = 0; i < 12; i++) begin
      req = tab[i].req;
      @(negedge clock);
      chk($sformatf("v%0d_gnt_rr", i), 32'(g0), 32'(tab[i].g0));
      chk($sformatf("v%0d_gnt_fp", i), 32'(g1), 32'(tab[i].g1));
      chk($sformatf("v%0d_rvalid_rr", i), 32'(rv0), 32'(tab[i].rv0));
      chk($sformatf("v%0d_rvalid_fp", i), 32'(rv1), 32'(tab[i].rv1));
      if (tab[i].rv0 != 4'b0000) chk($sformatf("v%0d_rdata_rr", i), 32'(rd0), 32'(tab[i].rd0));
      if (tab[i].rv1 != 4'b0000) chk($sformatf("v%0d_rdata_fp", i), 32'(rd1), 32'(tab[i].rd1));
      nxt();
    end
    @(negedge clock);
    chk("idle_mem_a_hold", 32'(ma0), 32'h2303);
    chk("idle_mem_w", 32'(mw0), 32'h0);
    nxt();

    // Write then read of the same address on the next cycle.
    set_addr(1, 16'h0300);
    wdata[15:8] = 8'hA5;
    req = 4'b0010;
    we  = 4'b0010;
    @(negedge clock);
    chk("wr_gnt", 32'(g0), 32'h2);
    chk("wr_mem_w", 32'(mw0), 32'h1);
    chk("wr_mem_a", 32'(ma0), 32'h0300);
    chk("wr_mem_d", 32'(md0), 32'hA5);
    nxt();
    set_addr(2, 16'h0300);
    req = 4'b0100;
    we  = 4'b0000;
    @(negedge clock);
    chk("rd_gnt", 32'(g0), 32'h4);
    chk("wr_no_rvalid_rr", 32'(rv0), 32'h0);
    chk("wr_no_rvalid_fp", 32'(rv1), 32'h0);
    nxt();
    req = 4'b0000;
    @(negedge clock);
    chk("raw_rvalid_rr", 32'(rv0), 32'h4);
    chk("raw_rdata_rr", 32'(rd0), 32'hA5);
    chk("raw_rvalid_fp", 32'(rv1), 32'h4);
    chk("raw_rdata_fp", 32'(rd1), 32'hA5);
    nxt();

    // Locked 256-read burst on ch2 while ch0 keeps requesting.
    n0 = 0;
    n1 = 0;
    e0 = 0;
    lock = 4'b0100;
    req  = 4'b0100;
    set_addr(0, 16'h0040);
    for (int k = 0; k < 256; k++) begin
      if (k == 1) req = 4'b0101;
      set_addr(2, 16'h1000 + 16'(k));
      @(negedge clock);
      if (g0 == 4'b0100) n0++;
      if (g1 == 4'b0100) n1++;
      if (k > 0 && !(rv0 == 4'b0100 && rd0 == pat(16'h1000 + 16'(k - 1)))) e0++;
      nxt();
    end
    req  = 4'b0001;
    lock = 4'b0000;
    @(negedge clock);
    chk("burst_count_rr", 32'(n0), 32'd256);
    chk("burst_count_fp", 32'(n1), 32'd256);
    chk("burst_data_errors", 32'(e0), 32'd0);
    chk("burst_release_rr", 32'(g0), 32'h1);
    chk("burst_release_fp", 32'(g1), 32'h1);
    chk("burst_last_rdata", 32'(rd0), 32'(pat(16'h10FF)));
    nxt();

    // Reset right after granting a ch3 read.
    req = 4'b1000;
    @(negedge clock);
    chk("mid_rd_gnt", 32'(g0), 32'h8);
    nxt();
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clock);
    chk("mid_rd_rvalid_rr", 32'(rv0), 32'h0);
    chk("mid_rd_rvalid_fp", 32'(rv1), 32'h0);
    nxt();
    @(negedge clock);
    chk("mid_rd_rvalid_hold", 32'(rv0), 32'h0);
    nxt();
    reset = 1'b0;
    req   = 4'b1111;
    @(negedge clock);
    chk("post_reset_gnt", 32'(g0), 32'h1);
    chk("post_reset_rvalid", 32'(rv0), 32'h0);
    nxt();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
